// File: rtl/edge_seq_pkg.sv
// Shared types for the edge-sequence monitor: event modes, FSM states and
// the per-step match helper.
package edge_seq_pkg;

  typedef enum logic [1:0] {
    RISE   = 2'b00,
    FALL   = 2'b01,
    ANY    = 2'b10,
    LVL_HI = 2'b11
  } edge_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FAIL
  } seq_state_t;

  localparam logic [1:0] MODE_RISE   = 2'b00;
  localparam logic [1:0] MODE_FALL   = 2'b01;
  localparam logic [1:0] MODE_ANY    = 2'b10;
  localparam logic [1:0] MODE_LVL_HI = 2'b11;

  function automatic logic mode_hit(input edge_mode_t mode, input logic rise,
                                    input logic fall, input logic any,
                                    input logic lvl);
    logic hit;
    hit = 1'b0;
    unique case (mode)
      RISE:   hit = rise;
      FALL:   hit = fall;
      ANY:    hit = any;
      LVL_HI: hit = lvl;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_seq_monitor_edge_det.sv
// Per-channel edge detector; edges are suppressed until one valid previous
// sample exists after reset.
module edge_det #(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sig,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] any
);

  logic [N_CH-1:0] prev;
  logic            prev_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev     <= sig;
      prev_vld <= 1'b1;
    end
  end

  always_comb begin
    rise = {N_CH{prev_vld}} & ~prev & sig;
    fall = {N_CH{prev_vld}} & prev & ~sig;
    any  = rise | fall;
  end

endmodule

// File: rtl/edge_seq_monitor.sv
// Ordered edge/level event checker with per-step snapshot capture and
// inter-event timeout.
module edge_seq_monitor
  import edge_seq_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DEPTH = 8,
  parameter int TO_W  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1),
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    sig_i,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [CW-1:0]      prog_ch,
  input  logic [1:0]         prog_mode,
  input  logic [LW-1:0]      prog_len,
  input  logic [TO_W-1:0]    timeout_i,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [LW-1:0]      step,
  input  logic [AW-1:0]      cap_addr,
  output logic [N_CH+TO_W-1:0] cap_rdata
);

  seq_state_t state, state_nxt;
  logic [LW-1:0]   step_nxt, step_inc, len_q, len_nxt;
  logic [TO_W-1:0] delta, delta_nxt, d_inc, to_q, to_nxt;
  logic [N_CH-1:0] rise, fall, any;
  logic [CW-1:0]   cur_ch;
  edge_mode_t      cur_mode;
  logic            hit, cap_we;

  logic [CW-1:0]         prog_ch_mem   [DEPTH];
  edge_mode_t            prog_mode_mem [DEPTH];
  logic [N_CH+TO_W-1:0]  cap_mem       [DEPTH];

  edge_det #(.N_CH(N_CH)) u_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (sig_i),
    .rise  (rise),
    .fall  (fall),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (prog_we && state != RUN) begin
      prog_ch_mem[prog_addr]   <= prog_ch;
      prog_mode_mem[prog_addr] <= edge_mode_t'(prog_mode);
    end
  end

  // step < len <= DEPTH while in RUN, so the low AW bits index the step
  always_comb begin
    cur_ch   = prog_ch_mem[step[AW-1:0]];
    cur_mode = prog_mode_mem[step[AW-1:0]];
    hit      = mode_hit(cur_mode, rise[cur_ch], fall[cur_ch], any[cur_ch],
                        sig_i[cur_ch]);
    step_inc = step + LW'(1);
    d_inc    = (delta == '1) ? delta : delta + TO_W'(1);
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    delta_nxt = delta;
    len_nxt   = len_q;
    to_nxt    = to_q;
    cap_we    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        RUN: begin
          if (hit) begin
            cap_we    = 1'b1;
            step_nxt  = step_inc;
            delta_nxt = '0;
            if (step_inc == len_q) state_nxt = DONE;
          end else begin
            delta_nxt = d_inc;
            if (to_q != '0 && d_inc == to_q) state_nxt = FAIL;
          end
        end
        default: begin
          if (start && prog_len != '0) begin
            state_nxt = RUN;
            step_nxt  = '0;
            delta_nxt = '0;
            len_nxt   = prog_len;
            to_nxt    = timeout_i;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      delta <= '0;
      len_q <= '0;
      to_q  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      delta <= delta_nxt;
      len_q <= len_nxt;
      to_q  <= to_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_we) cap_mem[step[AW-1:0]] <= {d_inc, sig_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cap_rdata <= '0;
    else        cap_rdata <= cap_mem[cap_addr];
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    fail = (state == FAIL);
  end

endmodule

// File: tb/tb_edge_seq_monitor.sv
// Directed checks of edge_seq_monitor with hand-computed expected values.
module tb_edge_seq_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sig_i;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [1:0]  prog_ch;
  logic [1:0]  prog_mode;
  logic [3:0]  prog_len;
  logic [15:0] timeout_i;
  logic        start;
  logic        abort;
  logic        busy, done, fail;
  logic [3:0]  step;
  logic [2:0]  cap_addr;
  logic [19:0] cap_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  edge_seq_monitor #(.N_CH(4), .DEPTH(8), .TO_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_i     (sig_i),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_ch   (prog_ch),
    .prog_mode (prog_mode),
    .prog_len  (prog_len),
    .timeout_i (timeout_i),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .step      (step),
    .cap_addr  (cap_addr),
    .cap_rdata (cap_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [2:0] addr, input logic [1:0] ch,
                      input logic [1:0] mode);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_ch   = ch;
    prog_mode = mode;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic go(input logic [3:0] len, input logic [15:0] to);
    prog_len  = len;
    timeout_i = to;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // event lands k cycles after the previous start/match edge
  task automatic wait_ev(input int unsigned k, input logic [3:0] s);
    repeat (k - 1) tick();
    sig_i = s;
    tick();
  endtask

  task automatic rd_cap(input string tag, input logic [2:0] addr,
                        input logic [19:0] exp);
    cap_addr = addr;
    tick();
    chk(tag, cap_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; sig_i = 4'b0001; prog_we = 1'b0; prog_addr = '0;
    prog_ch = '0; prog_mode = '0; prog_len = '0; timeout_i = '0;
    start = 1'b0; abort = 1'b0; cap_addr = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_step", step, 0);
    chk("rst_rdata", cap_rdata, 0);
    rst_n = 1'b1;
    tick();

    // basic three-step sequence
    prog(0, 1, 2'b00);
    prog(1, 0, 2'b01);
    prog(2, 2, 2'b10);
    go(0, 0);
    chk("len0_ignored", busy, 0);
    go(3, 0);
    chk("t1_busy", busy, 1);
    wait_ev(5, 4'b0011);
    chk("t1_step1", step, 1);
    wait_ev(3, 4'b0010);
    chk("t1_step2", step, 2);
    wait_ev(7, 4'b0110);
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_step3", step, 3);
    rd_cap("t1_cap0", 0, {16'd5, 4'b0011});
    rd_cap("t1_cap1", 1, {16'd3, 4'b0010});
    rd_cap("t1_cap2", 2, {16'd7, 4'b0110});

    // simultaneous events consume only one step
    sig_i = 4'b0000;
    tick(); tick();
    prog(0, 0, 2'b00);
    prog(1, 1, 2'b00);
    go(2, 0);
    sig_i = 4'b0011;
    tick();
    chk("t2_step1", step, 1);
    tick();
    chk("t2_hold", step, 1);
    chk("t2_busy", busy, 1);
    tick();
    sig_i = 4'b0001; tick();
    sig_i = 4'b0011; tick();
    chk("t2_done", done, 1);
    chk("t2_step2", step, 2);
    rd_cap("t2_cap0", 0, {16'd1, 4'b0011});
    rd_cap("t2_cap1", 1, {16'd4, 4'b0011});

    // timeout with a step that never occurs
    prog(0, 3, 2'b00);
    go(1, 10);
    chk("t3_busy", busy, 1);
    repeat (9) tick();
    chk("t3_nofail9", fail, 0);
    chk("t3_busy9", busy, 1);
    tick();
    chk("t3_fail10", fail, 1);
    chk("t3_step", step, 0);

    // match on the timeout cycle wins
    go(1, 5);
    wait_ev(5, 4'b1011);
    chk("t4_done", done, 1);
    chk("t4_nofail", fail, 0);
    rd_cap("t4_cap0", 0, {16'd5, 4'b1011});

    // input high through reset: no spurious rise, level-high matches at once
    sig_i = 4'b0001;
    rst_n = 1'b0;
    tick(); tick();
    chk("t5_rst_done", done, 0);
    chk("t5_rst_step", step, 0);
    rst_n = 1'b1;
    prog(0, 0, 2'b00);
    go(1, 0);
    repeat (3) tick();
    chk("t5_no_rise", step, 0);
    chk("t5_busy", busy, 1);
    sig_i = 4'b0000; tick();
    sig_i = 4'b0001; tick();
    chk("t5_rise_done", done, 1);
    prog(0, 0, 2'b11);
    go(1, 0);
    tick();
    chk("t5_lvl_done", done, 1);
    chk("t5_lvl_step", step, 1);
    rd_cap("t5_cap0", 0, {16'd1, 4'b0001});

    // abort mid-run, capture retained
    prog(0, 2, 2'b00);
    go(1, 0);
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_done", done, 0);
    chk("t6_abort_fail", fail, 0);
    rd_cap("t6_cap_kept", 0, {16'd1, 4'b0001});

    // program writes ignored while running
    go(1, 0);
    prog(0, 0, 2'b11);
    tick(); tick();
    chk("t6_we_ignored", step, 0);
    chk("t6_we_busy", busy, 1);
    sig_i = 4'b0101; tick();
    chk("t6_ch2_done", done, 1);

    // reset mid-run
    go(1, 0);
    chk("t7_busy", busy, 1);
    rst_n = 1'b0; tick();
    chk("t7_busy0", busy, 0);
    chk("t7_done0", done, 0);
    chk("t7_fail0", fail, 0);
    chk("t7_step0", step, 0);
    chk("t7_rdata0", cap_rdata, 0);
    rst_n = 1'b1; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
